cavlc_coeff_token_ctrl: RTL and testbench
=========================================

# cavlc_coeff_token_ctrl

Sequencer for coeff_token encoding in the CAVLC entropy coder. It takes one request per 4x4 block (TotalCoeff, TrailingOnes and the neighbour counts), derives nC, and picks the coeff_token table. It then drives the external coeff_token lookup ROMs, or generates the fixed-length code internally, and hands the resulting {length, code} pair to the bitstream packer over a valid/ready handshake. It also keeps a per-macroblock count of coeff_token bits for rate control.

## Interface
- LEN_W, 5, code length width (max length 16)
- CODE_W, 16, code value width, right-aligned
- CNT_W, 16, per-MB bit counter width
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- mb_start  in  1  one-cycle pulse; clears bit counter
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_total_coeff  in  5  TotalCoeff, 0..16
- req_t1  in  2  TrailingOnes, 0..3
- req_chroma_dc  in  1  use chroma-DC table (nC = -1)
- req_na_avail, req_nb_avail  in  1 each  left/top neighbour available
- req_na, req_nb  in  5 each  neighbour TotalCoeff
- tbl_sel  out  3  0 VLC0, 1 VLC1, 2 VLC2, 4 chroma DC (3 = FLC, no ROM)
- tbl_addr  out  7  {total_coeff, t1}
- tbl_len  in  LEN_W  combinational ROM length
- tbl_code  in  CODE_W  combinational ROM code
- out_valid  out  1  token valid
- out_ready  in  1  packer accepts
- out_len  out  LEN_W  token length
- out_code  out  CODE_W  token bits, right-aligned
- err  out  1  one-cycle pulse on illegal request
- bits_total  out  CNT_W  coeff_token bits emitted this MB

## Operation
- FSM states: IDLE, LOOK, OUT.
  - IDLE → LOOK on req_valid & req_ready with a legal request.
  - LOOK → OUT unconditionally.
  - OUT → IDLE on out_valid & out_ready.
- A request is illegal if any of these holds:
  - t1 > total_coeff
  - total_coeff > 16
  - chroma_dc with total_coeff > 4
- An illegal request is accepted, pulses err on the next cycle, stays in IDLE and produces no token.
- nC derivation, computed at accept and registered:
  - both neighbours available: (nA+nB+1)>>1, 6-bit sum
  - only A available: nA
  - only B available: nB
  - neither available: 0
- Table select:
  - chroma_dc → 4, overriding nC
  - nC 0..1 → 0
  - nC 2..3 → 1
  - nC 4..7 → 2
  - nC ≥ 8 → 3
- tbl_addr = total_coeff*4 + t1, registered; tbl_sel and tbl_addr are held stable through LOOK and OUT.
- LOOK captures the token into the output registers:
  - ROM tables: captures tbl_len/tbl_code.
  - FLC (sel 3): len = 6; code = 6'b000011 if total_coeff = 0, else ((total_coeff-1)<<2)|t1.
- out_len and out_code are held until the handshake completes.
- bits_total:
  - adds out_len on each out handshake and saturates at all-ones.
  - mb_start clears it to 0.
  - If mb_start coincides with a handshake, the result is out_len.

## Timing
- Reset values: state IDLE, req_ready 1, out_valid 0, out_len 0, out_code 0, tbl_sel 0, tbl_addr 0, err 0, bits_total 0.
- Request accepted at cycle T:
  - tbl_sel/tbl_addr valid at T+1 (LOOK).
  - out_valid rises at T+2.
- Minimum spacing between tokens is 3 cycles: req_ready returns high the cycle after the out handshake.
- out_valid must not drop and out_len/out_code must not change while out_ready is low.
- Reset asserted mid-operation: FSM returns to IDLE, the in-flight token is discarded, outputs go to their reset values on the next edge.

## Structure
- Shared package constants:
  - table-select encodings TBL_VLC0/1/2/FLC/CDC
  - LEN_W and CODE_W
  - FSM state encodings
- Sub-module nc_calc: combinational nC derivation and table-select mapping, reused by the decoder-side model.
- ROMs stay external; this block only sequences them.

## Test plan
- nA=3, nB=2, both available, TC=2, T1=1 → tbl_sel=1, tbl_addr=9 at T+1; out_valid at T+2 with the ROM model's VLC1 entry.
- Neither neighbour available, TC=0, T1=0, ROM model returns len 1 code 1 → out_len=1, out_code=1; bits_total=1 after the handshake.
- nA=8, only A available, TC=3, T1=2 → sel 3, out_len=6, out_code=6'b001010; TC=0 case → 6'b000011.
- chroma_dc, TC=5 → err pulse, no out_valid, req_ready stays high; TC=2, T1=3 → err.
- out_ready held low 5 cycles in OUT → out_valid/out_len/out_code stable, req_ready low; mb_start coincident with the handshake of len 4 → bits_total=4.
- Assert rst_n low during LOOK → next cycle IDLE, out_valid 0, bits_total 0; the following request completes normally.

Source files
------------

// File: rtl/cavlc_coeff_token_ctrl_pkg.sv
// Shared constants for the CAVLC coeff_token sequencer: table-select codes,
// token field widths and FSM state encodings.
package cavlc_coeff_token_ctrl_pkg;

  localparam int LEN_W  = 5;
  localparam int CODE_W = 16;

  localparam logic [2:0] TBL_VLC0 = 3'd0;
  localparam logic [2:0] TBL_VLC1 = 3'd1;
  localparam logic [2:0] TBL_VLC2 = 3'd2;
  localparam logic [2:0] TBL_FLC  = 3'd3;
  localparam logic [2:0] TBL_CDC  = 3'd4;

  localparam int FLC_LEN = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOOK = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/cavlc_coeff_token_ctrl_nc_calc.sv
// Combinational nC derivation from neighbour counts and mapping of nC onto
// the coeff_token table select; shared with the decoder-side model.
module cavlc_coeff_token_ctrl_nc_calc
  import cavlc_coeff_token_ctrl_pkg::*;
(
  input  logic       chroma_dc,
  input  logic       na_avail,
  input  logic       nb_avail,
  input  logic [4:0] na,
  input  logic [4:0] nb,
  output logic [2:0] tbl_sel
);

  logic [5:0] nc_sum;
  logic [4:0] nc;

  // Rounded average needs the 6-bit sum so the +1 cannot wrap.
  assign nc_sum = {1'b0, na} + {1'b0, nb} + 6'd1;

  always_comb begin
    nc = 5'd0;
    if (na_avail && nb_avail) nc = nc_sum[5:1];
    else if (na_avail)        nc = na;
    else if (nb_avail)        nc = nb;
  end

  always_comb begin
    tbl_sel = TBL_FLC;
    if (chroma_dc)         tbl_sel = TBL_CDC;
    else if (nc < 5'd2)    tbl_sel = TBL_VLC0;
    else if (nc < 5'd4)    tbl_sel = TBL_VLC1;
    else if (nc < 5'd8)    tbl_sel = TBL_VLC2;
  end

endmodule

// File: rtl/cavlc_coeff_token_ctrl.sv
// coeff_token sequencer: accepts one request per 4x4 block, drives the external
// ROMs (or builds the FLC code), and hands {len, code} to the packer.
module cavlc_coeff_token_ctrl #(
  parameter int LEN_W  = cavlc_coeff_token_ctrl_pkg::LEN_W,
  parameter int CODE_W = cavlc_coeff_token_ctrl_pkg::CODE_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mb_start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_total_coeff,
  input  logic [1:0]        req_t1,
  input  logic              req_chroma_dc,
  input  logic              req_na_avail,
  input  logic              req_nb_avail,
  input  logic [4:0]        req_na,
  input  logic [4:0]        req_nb,
  output logic [2:0]        tbl_sel,
  output logic [6:0]        tbl_addr,
  input  logic [LEN_W-1:0]  tbl_len,
  input  logic [CODE_W-1:0] tbl_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LEN_W-1:0]  out_len,
  output logic [CODE_W-1:0] out_code,
  output logic              err,
  output logic [CNT_W-1:0]  bits_total
);
  import cavlc_coeff_token_ctrl_pkg::*;

  state_e              state_q, state_d;
  logic [2:0]          tbl_sel_q, tbl_sel_d;
  logic [6:0]          tbl_addr_q, tbl_addr_d;
  logic [LEN_W-1:0]    out_len_q, out_len_d;
  logic [CODE_W-1:0]   out_code_q, out_code_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    bits_q, bits_d;

  logic [2:0]          sel_calc;
  logic                illegal;
  logic                out_hs;
  logic [4:0]          tc_m1;
  logic [5:0]          flc_code;
  logic [CNT_W:0]      bits_sum;

  cavlc_coeff_token_ctrl_nc_calc u_nc_calc (
    .chroma_dc (req_chroma_dc),
    .na_avail  (req_na_avail),
    .nb_avail  (req_nb_avail),
    .na        (req_na),
    .nb        (req_nb),
    .tbl_sel   (sel_calc)
  );

  assign illegal = ({3'b000, req_t1} > req_total_coeff) ||
                   (req_total_coeff > 5'd16) ||
                   (req_chroma_dc && (req_total_coeff > 5'd4));

  // FLC fields come back out of the held address: total_coeff in [6:2], t1 in [1:0].
  assign tc_m1    = tbl_addr_q[6:2] - 5'd1;
  assign flc_code = (tbl_addr_q[6:2] == 5'd0) ? 6'b000011 : {tc_m1[3:0], tbl_addr_q[1:0]};

  assign out_hs   = (state_q == ST_OUT) && out_ready;
  assign bits_sum = {1'b0, bits_q} + (CNT_W + 1)'(out_len_q);

  always_comb begin
    state_d    = state_q;
    tbl_sel_d  = tbl_sel_q;
    tbl_addr_d = tbl_addr_q;
    out_len_d  = out_len_q;
    out_code_d = out_code_q;
    err_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_LOOK;
            tbl_sel_d  = sel_calc;
            tbl_addr_d = {req_total_coeff, req_t1};
          end
        end
      end
      ST_LOOK: begin
        state_d = ST_OUT;
        if (tbl_sel_q == TBL_FLC) begin
          out_len_d  = LEN_W'(FLC_LEN);
          out_code_d = {{(CODE_W-6){1'b0}}, flc_code};
        end else begin
          out_len_d  = tbl_len;
          out_code_d = tbl_code;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new MB discards the old count but still books a token leaving this cycle.
  always_comb begin
    bits_d = bits_q;
    if (mb_start)    bits_d = out_hs ? CNT_W'(out_len_q) : '0;
    else if (out_hs) bits_d = bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tbl_sel_q  <= '0;
      tbl_addr_q <= '0;
      out_len_q  <= '0;
      out_code_q <= '0;
      err_q      <= 1'b0;
      bits_q     <= '0;
    end else begin
      state_q    <= state_d;
      tbl_sel_q  <= tbl_sel_d;
      tbl_addr_q <= tbl_addr_d;
      out_len_q  <= out_len_d;
      out_code_q <= out_code_d;
      err_q      <= err_d;
      bits_q     <= bits_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_OUT);
  assign tbl_sel    = tbl_sel_q;
  assign tbl_addr   = tbl_addr_q;
  assign out_len    = out_len_q;
  assign out_code   = out_code_q;
  assign err        = err_q;
  assign bits_total = bits_q;

endmodule

// File: tb/tb_cavlc_coeff_token_ctrl.sv
// Self-checking bench: scoreboard of expected tokens, ROM behavioural model,
// scenario tasks run in sequence from one initial block.
module tb_cavlc_coeff_token_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mb_start;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_total_coeff;
  logic [1:0]  req_t1;
  logic        req_chroma_dc;
  logic        req_na_avail;
  logic        req_nb_avail;
  logic [4:0]  req_na;
  logic [4:0]  req_nb;
  logic [2:0]  tbl_sel;
  logic [6:0]  tbl_addr;
  logic [4:0]  tbl_len;
  logic [15:0] tbl_code;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_len;
  logic [15:0] out_code;
  logic        err;
  logic [15:0] bits_total;

  typedef struct {
    logic [4:0]  len;
    logic [15:0] code;
  } tok_t;

  tok_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   bits_exp = 0;

  always #5 clk = ~clk;

  cavlc_coeff_token_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mb_start        (mb_start),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_total_coeff (req_total_coeff),
    .req_t1          (req_t1),
    .req_chroma_dc   (req_chroma_dc),
    .req_na_avail    (req_na_avail),
    .req_nb_avail    (req_nb_avail),
    .req_na          (req_na),
    .req_nb          (req_nb),
    .tbl_sel         (tbl_sel),
    .tbl_addr        (tbl_addr),
    .tbl_len         (tbl_len),
    .tbl_code        (tbl_code),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_len         (out_len),
    .out_code        (out_code),
    .err             (err),
    .bits_total      (bits_total)
  );

  // Behavioural coeff_token ROM; VLC0 entry 0 is the real 1-bit code "1".
  function automatic logic [4:0] rom_len(input logic [2:0] s, input logic [6:0] a);
    int v;
    if (s == 3'd0 && a == 7'd0) return 5'd1;
    v = (int'(a) + int'(s) * 3) % 16 + 1;
    return 5'(v);
  endfunction

  function automatic logic [15:0] rom_code(input logic [2:0] s, input logic [6:0] a);
    int l;
    int v;
    if (s == 3'd0 && a == 7'd0) return 16'd1;
    l = int'(rom_len(s, a));
    v = (int'(a) * 37 + int'(s) * 11) & ((1 << l) - 1);
    return 16'(v);
  endfunction

  assign tbl_len  = rom_len(tbl_sel, tbl_addr);
  assign tbl_code = rom_code(tbl_sel, tbl_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [4:0] tc, input logic [1:0] t1, input logic cd,
                           input logic aa, input logic ba, input logic [4:0] na, input logic [4:0] nb);
    req_valid       = 1'b1;
    req_total_coeff = tc;
    req_t1          = t1;
    req_chroma_dc   = cd;
    req_na_avail    = aa;
    req_nb_avail    = ba;
    req_na          = na;
    req_nb          = nb;
  endtask

  task automatic test_reset();
    total++; if (req_ready !== 1'b1)  begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_len !== 5'd0)    begin bad++; $display("FAIL reset_out_len: got %0d want 0", out_len); end
    total++; if (out_code !== 16'd0)  begin bad++; $display("FAIL reset_out_code: got %0h want 0", out_code); end
    total++; if (tbl_sel !== 3'd0)    begin bad++; $display("FAIL reset_tbl_sel: got %0d want 0", tbl_sel); end
    total++; if (tbl_addr !== 7'd0)   begin bad++; $display("FAIL reset_tbl_addr: got %0d want 0", tbl_addr); end
    total++; if (err !== 1'b0)        begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (bits_total !== 16'd0) begin bad++; $display("FAIL reset_bits_total: got %0d want 0", bits_total); end
  endtask

  // Drives one legal request, pushes the expected token, checks LOOK and OUT timing.
  task automatic issue(input logic [4:0] tc, input logic [1:0] t1, input logic cd,
                       input logic aa, input logic ba, input logic [4:0] na, input logic [4:0] nb,
                       input logic [2:0] exp_sel, input logic [4:0] exp_len, input logic [15:0] exp_code);
    tok_t t;
    logic [6:0] exp_addr;
    t.len  = exp_len;
    t.code = exp_code;
    sb_q.push_back(t);
    exp_addr = 7'(int'(tc) * 4 + int'(t1));
    drive_req(tc, t1, cd, aa, ba, na, nb);
    step();
    req_valid = 1'b0;
    total++; if (tbl_sel !== exp_sel)   begin bad++; $display("FAIL look_tbl_sel: got %0d want %0d", tbl_sel, exp_sel); end
    total++; if (tbl_addr !== exp_addr) begin bad++; $display("FAIL look_tbl_addr: got %0d want %0d", tbl_addr, exp_addr); end
    total++; if (req_ready !== 1'b0 || out_valid !== 1'b0)
      begin bad++; $display("FAIL look_flags: got ready=%b valid=%b want 0 0", req_ready, out_valid); end
    step();
    total++; if (out_valid !== 1'b1)    begin bad++; $display("FAIL out_valid_t2: got %b want 1", out_valid); end
    total++; if (tbl_sel !== exp_sel || tbl_addr !== exp_addr)
      begin bad++; $display("FAIL tbl_hold: got sel=%0d addr=%0d want sel=%0d addr=%0d", tbl_sel, tbl_addr, exp_sel, exp_addr); end
  endtask

  // Waits for a token, optionally stalls, then completes the handshake and checks it.
  task automatic drain(input int hold, input logic mb);
    tok_t e;
    int waited = 0;
    while (out_valid !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL drain_timeout: got out_valid=%b want 1", out_valid);
      return;
    end
    if (sb_q.size() == 0) begin
      total++; bad++; $display("FAIL scoreboard_empty: got 0 entries want 1");
      return;
    end
    e = sb_q.pop_front();
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_len !== e.len || out_code !== e.code || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: got valid=%b len=%0d code=%0h ready=%b want 1 %0d %0h 0",
                 out_valid, out_len, out_code, req_ready, e.len, e.code);
      end
    end
    total++; if (out_len !== e.len)   begin bad++; $display("FAIL out_len: got %0d want %0d", out_len, e.len); end
    total++; if (out_code !== e.code) begin bad++; $display("FAIL out_code: got %0h want %0h", out_code, e.code); end
    out_ready = 1'b1;
    mb_start  = mb;
    step();
    out_ready = 1'b0;
    mb_start  = 1'b0;
    if (mb) bits_exp = int'(e.len);
    else    bits_exp = (bits_exp + int'(e.len) > 65535) ? 65535 : bits_exp + int'(e.len);
    total++; if (bits_total !== 16'(bits_exp)) begin bad++; $display("FAIL bits_total: got %0d want %0d", bits_total, bits_exp); end
    total++; if (req_ready !== 1'b1 || out_valid !== 1'b0)
      begin bad++; $display("FAIL post_hs: got ready=%b valid=%b want 1 0", req_ready, out_valid); end
    $display("txn len=%0d code=%0h bits_total=%0d", e.len, e.code, bits_total);
  endtask

  task automatic test_vlc0();
    issue(5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 5'd1, 16'd1);
    drain(0, 1'b0);
    issue(5'd16, 2'd3, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 3'd0, rom_len(3'd0, 7'd67), rom_code(3'd0, 7'd67));
    drain(0, 1'b0);
  endtask

  task automatic test_vlc1();
    issue(5'd2, 2'd1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd2, 3'd1, rom_len(3'd1, 7'd9), rom_code(3'd1, 7'd9));
    drain(0, 1'b0);
    issue(5'd1, 2'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd5, 3'd2, rom_len(3'd2, 7'd4), rom_code(3'd2, 7'd4));
    drain(0, 1'b0);
  endtask

  task automatic test_flc();
    issue(5'd3, 2'd2, 1'b0, 1'b1, 1'b0, 5'd8, 5'd0, 3'd3, 5'd6, 16'b001010);
    drain(0, 1'b0);
    issue(5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 5'd8, 5'd0, 3'd3, 5'd6, 16'b000011);
    drain(0, 1'b0);
  endtask

  task automatic test_chroma_dc();
    issue(5'd4, 2'd1, 1'b1, 1'b1, 1'b1, 5'd20, 5'd20, 3'd4, rom_len(3'd4, 7'd17), rom_code(3'd4, 7'd17));
    drain(0, 1'b0);
  endtask

  task automatic test_illegal(input logic [4:0] tc, input logic [1:0] t1, input logic cd);
    drive_req(tc, t1, cd, 1'b0, 1'b0, 5'd0, 5'd0);
    step();
    req_valid = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err: got %b want 1 (tc=%0d t1=%0d)", err, tc, t1); end
    total++; if (req_ready !== 1'b1 || out_valid !== 1'b0)
      begin bad++; $display("FAIL illegal_state: got ready=%b valid=%b want 1 0", req_ready, out_valid); end
    step();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL illegal_err_pulse: got %b want 0", err); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL illegal_no_token: got %b want 0", out_valid); end
    end
    $display("txn illegal tc=%0d t1=%0d cd=%b", tc, t1, cd);
  endtask

  task automatic test_back_to_back();
    issue(5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 5'd2, 5'd0, 3'd1, 5'd4, rom_code(3'd1, 7'd0));
    drain(5, 1'b1);
  endtask

  task automatic test_reset_mid();
    drive_req(5'd1, 2'd1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bits_exp = 0;
    total++; if (req_ready !== 1'b1 || out_valid !== 1'b0)
      begin bad++; $display("FAIL midrst_state: got ready=%b valid=%b want 1 0", req_ready, out_valid); end
    total++; if (bits_total !== 16'd0) begin bad++; $display("FAIL midrst_bits: got %0d want 0", bits_total); end
    total++; if (tbl_sel !== 3'd0 || tbl_addr !== 7'd0)
      begin bad++; $display("FAIL midrst_tbl: got sel=%0d addr=%0d want 0 0", tbl_sel, tbl_addr); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_discard: got %b want 0", out_valid); end
    $display("txn reset during LOOK");
    issue(5'd5, 2'd3, 1'b0, 1'b1, 1'b1, 5'd4, 5'd5, 3'd2, rom_len(3'd2, 7'd23), rom_code(3'd2, 7'd23));
    drain(0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    mb_start  = 1'b0;
    out_ready = 1'b0;
    drive_req(5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    req_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    test_reset();
    step();
    test_vlc0();
    test_vlc1();
    test_flc();
    test_chroma_dc();
    test_illegal(5'd5, 2'd0, 1'b1);
    test_illegal(5'd2, 2'd3, 1'b0);
    test_illegal(5'd17, 2'd0, 1'b0);
    test_back_to_back();
    test_reset_mid();
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d want 0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
